// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output buffer
`ifndef DEFAULT_BAUD
`define DEFAULT_BAUD 115200
`endif
`ifndef CLK_PER_SEC
`define CLK_PER_SEC 50000000
`endif

module uart_rx #(
   parameter int BAUD        = `DEFAULT_BAUD,
   parameter int CLK_PER_SEC = `CLK_PER_SEC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rdata,
   output logic       rvalid,
   input  logic       rready,
   output logic       ferr,
   output logic       overrun
);

   localparam int HALF = CLK_PER_SEC / BAUD / 2;
   localparam int BIT  = 2 * HALF;
   localparam int CW   = ($clog2(BIT) + 1 > 16) ? ($clog2(BIT) + 1) : 16;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          rx_meta;
   logic          rxs;

   // Two-flop synchronizer; idle-high reset value keeps reset from looking like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx     <= 3'd0;
         shreg   <= 8'h00;
         rdata   <= 8'h00;
         rvalid  <= 1'b0;
         ferr    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         ferr    <= 1'b0;
         overrun <= 1'b0;
         if (rvalid && rready)
            rvalid <= 1'b0;

         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (!rxs)
                  state <= S_START;
            end

            S_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  idx <= 3'd0;
                  state <= rxs ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt        <= '0;
                  shreg[idx] <= rxs;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7)
                     state <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rxs) begin
                     // Leaving at mid-stop-bit lets an immediately following start bit be caught.
                     state <= S_IDLE;
                     if (!rvalid || rready) begin
                        rdata  <= shreg;
                        rvalid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     ferr  <= 1'b1;
                     state <= S_BRK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_BRK: begin
               cnt <= '0;
               if (rxs)
                  state <= S_IDLE;
            end

            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
